// File: rtl/lfsr_galois_param.sv
// Parametrised Galois LFSR with seed load, zero-load protection, multi-step advance
// and on-line period measurement (wrap pulse + period register).
module lfsr_galois_param #(
   parameter int                WIDTH = 5,
   parameter logic [WIDTH-1:0]  TAPS  = 5'h14,
   parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int                STEPS = 1,
   parameter int                CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             wrap,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             lock_err
);

   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0] adv_cnt_q, adv_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             wrap_q, wrap_d;
   logic             period_valid_q, period_valid_d;
   logic             lock_err_q, lock_err_d;

   logic [WIDTH-1:0] step_state;
   logic [CNT_W-1:0] cnt_inc;

   function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   // STEPS single steps chained combinationally into one register update
   always_comb begin
      step_state = lfsr_q;
      for (int i = 0; i < STEPS; i++) begin
         step_state = galois_step(step_state);
      end
   end

   assign cnt_inc = (adv_cnt_q == {CNT_W{1'b1}}) ? adv_cnt_q : adv_cnt_q + 1'b1;

   always_comb begin
      lfsr_d         = lfsr_q;
      adv_cnt_d      = adv_cnt_q;
      period_d       = period_q;
      wrap_d         = 1'b0;
      period_valid_d = period_valid_q;
      lock_err_d     = lock_err_q;
      if (load) begin
         adv_cnt_d = '0;
         if (load_data != '0) begin
            lfsr_d     = load_data;
            lock_err_d = 1'b0;
         end else begin
            lfsr_d     = SEED;
            lock_err_d = 1'b1;
         end
      end else if (en) begin
         lfsr_d = step_state;
         // only the final state of a multi-step advance is compared with SEED
         if (step_state == SEED) begin
            wrap_d         = 1'b1;
            period_d       = cnt_inc;
            period_valid_d = 1'b1;
            adv_cnt_d      = '0;
         end else begin
            adv_cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q         <= SEED;
         adv_cnt_q      <= '0;
         period_q       <= '0;
         wrap_q         <= 1'b0;
         period_valid_q <= 1'b0;
         lock_err_q     <= 1'b0;
      end else begin
         lfsr_q         <= lfsr_d;
         adv_cnt_q      <= adv_cnt_d;
         period_q       <= period_d;
         wrap_q         <= wrap_d;
         period_valid_q <= period_valid_d;
         lock_err_q     <= lock_err_d;
      end
   end

   assign lfsr_out     = lfsr_q;
   assign wrap         = wrap_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign lock_err     = lock_err_q;

endmodule

// File: doc/lfsr_galois_param.md
# lfsr_galois_param

Parametrised Galois LFSR generator: the general-width, loadable, multi-step successor to the fixed 5-bit LFSR. It provides pseudo-random state for test-pattern, scrambler and BIST paths. It adds enable, seed load with zero-state protection, N-steps-per-cycle advance, and on-line period measurement through a wrap pulse and a period register.

## Interface
- WIDTH, 5: state width in bits, 2..32.
- TAPS, 5'h14: Galois feedback mask, WIDTH bits. The default is x^5+x^3+1.
- SEED, 1: reset state, and the substitute for an illegal all-zero load. Must be non-zero.
- STEPS, 1: LFSR steps applied per enabled cycle, 1..WIDTH.
- CNT_W, 16: width of the advance counter and the period register.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  advance the state by STEPS steps this cycle.
- load  in  1  load load_data this cycle. Has priority over en.
- load_data  in  WIDTH  seed value to load.
- lfsr_out  out  WIDTH  current state (registered).
- wrap  out  1  one-cycle pulse: an advance produced state == SEED.
- period  out  CNT_W  number of advances between the last two events (wrap, or load followed by wrap).
- period_valid  out  1  period holds a measured value.
- lock_err  out  1  sticky flag: an all-zero load was attempted.

## Operation
- Single step: s' = (s >> 1) ^ (s[0] ? TAPS : 0).
- One enabled cycle applies the single step STEPS times, combinationally chained, into one register update.
- Per-cycle priority: reset_n low > load > en > hold.
- Reset (async assert, sync release):
  - lfsr_out = SEED; wrap = 0; period = 0; period_valid = 0; lock_err = 0.
  - Internal advance counter adv_cnt = 0.
- Load:
  - If load_data != 0: lfsr_out = load_data, lock_err cleared.
  - If load_data == 0: lfsr_out = SEED, lock_err set.
  - Both cases: adv_cnt = 0, wrap = 0. period and period_valid hold.
- Advance (en && !load):
  - lfsr_out = next state; adv_cnt += 1, saturating at all-ones.
  - If the next state == SEED: wrap = 1, period = adv_cnt + 1 (saturated), period_valid = 1, adv_cnt = 0.
  - Only the final state of the cycle is compared with SEED. Intermediate steps of a multi-step advance are not checked.
- Hold (!en && !load): all registers keep their values; wrap = 0.
- The all-zero state is unreachable from a non-zero state with a valid TAPS mask. No other recovery logic is required.

## Timing
- All outputs are registered. lfsr_out, wrap and period update on the same clk edge that accepts load or en.
- Load-to-output latency: 1 cycle. Advance latency: 1 cycle per STEPS steps.
- wrap is high for exactly one cycle per qualifying advance. Back-to-back wraps are legal, e.g. when the period divides into consecutive cycles.
- Asserting reset_n mid-sequence forces the reset values immediately, independent of clk.
- The first clk edge after reset_n deasserts behaves as a normal cycle.
- load and en together: load wins, no advance, no wrap.

## Test plan
- Reset, then en=1 with the defaults: lfsr_out sequence is 0x01, 0x14, 0x0A, 0x05, 0x16, … The first wrap comes on the 31st advance, with period = 31 and period_valid = 1.
- Load 0x0A, then en=1 for 3 cycles: outputs 0x0A, 0x05, 0x16, 0x0B. adv_cnt restarts, and the next wrap reports period = 29.
- Load 0x00: lfsr_out = 0x01 and lock_err = 1. A subsequent load of 0x07 clears lock_err.
- load=1 and en=1 in the same cycle with load_data 0x1F: lfsr_out = 0x1F, no advance, wrap = 0.
- STEPS=2 instance, reset, en=1: outputs 0x01, 0x0A, 0x16, … A wrap occurs after 31 cycles (62 steps) with period = 31.
- Drop reset_n asynchronously mid-run, between edges: lfsr_out = 0x01 and period_valid = 0 immediately. Normal advance resumes on the first edge after release.
